// File: rtl/adc_seq_pkg.sv
// Shared widths, state encoding and tag layout for the ADC scan sequencer.
// Also holds the bit-search helpers used for channel selection.
package adc_seq_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int DATA_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] chan;
    } tag_t;

    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CH_W-1:0] highest_set(input logic [NUM_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_next_chan.sv
// Round-robin channel picker: next enabled channel above cur_chan (wrapping),
// plus the lowest and highest enabled channels of the mask.
module rr_next_chan
    import adc_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur_chan,
    output logic [CH_W-1:0]   next_chan,
    output logic              wrap,
    output logic [CH_W-1:0]   lowest,
    output logic [CH_W-1:0]   highest
);

    logic [CH_W-1:0] idx;

    // Scan from farthest to nearest so the nearest enabled channel wins;
    // offset NUM_CH lands back on cur_chan, which gives single-bit masks.
    always_comb begin
        next_chan = cur_chan;
        idx       = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = cur_chan + CH_W'(i);
            if (mask[idx]) next_chan = idx;
        end
    end

    assign wrap    = (next_chan <= cur_chan);
    assign lowest  = lowest_set(mask);
    assign highest = highest_set(mask);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Steps the ADC through the enabled channels one frame at a time and files
// each result, two frames later, into a readable per-channel bank.
module adc_scan_sequencer
    import adc_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              adc_convst,
    input  logic [DATA_W-1:0] adc_result,
    output logic [CH_W-1:0]   chan,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_chan,
    output logic [DATA_W-1:0] sample_data,
    output logic              scan_done,
    output logic              busy,
    input  logic [CH_W-1:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    state_t              state, state_next;
    logic [NUM_CH-1:0]   mask, mask_next, rr_mask;
    logic [CH_W-1:0]     chan_next, rr_next, rr_lowest, rr_highest;
    logic                rr_wrap;
    logic                convst_q, boundary;
    tag_t                tag0, tag1;
    logic                last0, last1;
    logic [DATA_W-1:0]   bank [NUM_CH];
    logic [NUM_CH-1:0]   bank_valid;

    assign boundary = adc_convst & ~convst_q;
    assign busy     = (state != IDLE);

    // While idle the picker looks at ch_enable so a start can pick its first channel.
    assign rr_mask = (state == IDLE) ? ch_enable : mask;

    rr_next_chan u_rr (
        .mask      (rr_mask),
        .cur_chan  (chan),
        .next_chan (rr_next),
        .wrap      (rr_wrap),
        .lowest    (rr_lowest),
        .highest   (rr_highest)
    );

    always_comb begin
        state_next = state;
        chan_next  = chan;
        mask_next  = mask;
        case (state)
            IDLE: begin
                if (start && (ch_enable != '0)) begin
                    state_next = SCAN;
                    mask_next  = ch_enable;
                    chan_next  = rr_lowest;
                end
            end
            SCAN: begin
                if (boundary) begin
                    if (!rr_wrap) begin
                        chan_next = rr_next;
                    end else if (continuous && (ch_enable != '0)) begin
                        mask_next = ch_enable;
                        chan_next = lowest_set(ch_enable);
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (boundary && !tag0.valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            chan  <= '0;
            mask  <= '0;
        end else begin
            state <= state_next;
            chan  <= chan_next;
            mask  <= mask_next;
        end
    end

    // last0/last1 ride alongside the tags so scan_done refers to the mask at issue time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_q     <= 1'b0;
            tag0         <= '0;
            tag1         <= '0;
            last0        <= 1'b0;
            last1        <= 1'b0;
            sample_valid <= 1'b0;
            sample_chan  <= '0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
            bank_valid   <= '0;
        end else begin
            convst_q     <= adc_convst;
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            if (boundary) begin
                tag1  <= tag0;
                last1 <= last0;
                tag0  <= {state == SCAN, chan};
                last0 <= (chan == rr_highest);
                if (tag1.valid) begin
                    sample_valid           <= 1'b1;
                    sample_chan            <= tag1.chan;
                    sample_data            <= adc_result;
                    scan_done              <= last1;
                    bank_valid[tag1.chan]  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (boundary && tag1.valid) bank[tag1.chan] <= adc_result;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= bank[rd_addr];
            rd_valid <= bank_valid[rd_addr];
        end
    end

endmodule
